// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator/decimator pair: counter width,
// accumulator sizing and the output round-and-saturate rule.
package cic_pkg;

  localparam int CNT_WIDTH = 8;

  // Minimum accumulator width: in_width + ceil(stages * log2(rate)).
  function automatic int acc_width(input int in_width, input int stages, input int rate);
    longint gain;
    int bits;
    gain = 1;
    bits = 0;
    for (int k = 0; k < stages; k++) gain = gain * rate;
    while ((longint'(1) << bits) < gain) bits++;
    return in_width + bits;
  endfunction

  // Round half up after an arithmetic right shift, then clamp to out_width.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] value,
                                                   input int out_width, input int shift);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t  = (value + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (t > hi) return hi;
    if (t < lo) return lo;
    return t;
  endfunction

endpackage

// File: rtl/cic_round_sat.sv
// Combinational round + saturate from the accumulator width down to the
// output sample width; shared by the interpolator and decimator output paths.
module cic_round_sat
  import cic_pkg::*;
#(
  parameter int ACC_WIDTH = 36,
  parameter int OUT_WIDTH = 18,
  parameter int OUT_SHIFT = 13
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] rounded
);

  assign rounded = OUT_WIDTH'(round_sat(64'(acc), OUT_WIDTH, OUT_SHIFT));

endmodule

// File: rtl/cic_interp10.sv
// CIC interpolator: low-rate comb pipeline, zero-stuffing, high-rate
// integrator chain, rounded and saturated registered output.
module cic_interp10
  import cic_pkg::*;
#(
  parameter int INTERPOLATION = 10,
  parameter int STAGES        = 5,
  parameter int IN_WIDTH      = 18,
  parameter int OUT_WIDTH     = 18,
  parameter int ACC_WIDTH     = 36,
  parameter int OUT_SHIFT     = 13
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        out_strobe,
  output logic                        in_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam logic [CNT_WIDTH-1:0] LAST_PHASE = CNT_WIDTH'(INTERPOLATION - 1);

  logic [CNT_WIDTH-1:0]        phase;
  logic                        pending;
  logic signed [ACC_WIDTH-1:0] comb  [STAGES];
  logic signed [ACC_WIDTH-1:0] dly   [STAGES];
  logic signed [ACC_WIDTH-1:0] integ [STAGES];
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] stuffed;
  logic signed [OUT_WIDTH-1:0] rounded;

  assign in_ext  = ACC_WIDTH'(in_data);
  assign stuffed = pending ? comb[STAGES-1] : '0;

  // Strobe semantics: out_strobe is an unconditional high-rate enable (no
  // back-pressure); in_strobe is a one-cycle request, and in_data is consumed
  // on every cycle in which in_strobe is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase     <= '0;
      in_strobe <= 1'b0;
    end else begin
      in_strobe <= 1'b0;
      if (out_strobe) begin
        if (phase == LAST_PHASE) begin
          phase     <= '0;
          in_strobe <= 1'b1;
        end else begin
          phase <= phase + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
    end else if (in_strobe) begin
      comb[0] <= in_ext - dly[0];
      dly[0]  <= in_ext;
      for (int k = 1; k < STAGES; k++) begin
        comb[k] <= comb[k-1] - dly[k];
        dly[k]  <= comb[k-1];
      end
    end
  end

  // A fresh comb result is injected exactly once, on the first out_strobe
  // after the in_strobe cycle; set wins when both strobes coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (in_strobe) begin
      pending <= 1'b1;
    end else if (out_strobe) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (out_strobe) begin
      integ[0] <= integ[0] + stuffed;
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  cic_round_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .acc     (integ[STAGES-1]),
    .rounded (rounded)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= out_strobe;
      if (out_strobe) out_data <= rounded;
    end
  end

endmodule

// File: tb/tb_cic_interp10.sv
// Bench for cic_interp10: closed-form CIC model (binomial differencing and
// cumulative-sum kernels) checked every cycle, plus hand-computed literals.
module tb_cic_interp10;

  localparam int R  = 10;
  localparam int N  = 5;
  localparam int IW = 18;
  localparam int OW = 18;
  localparam int AW = 36;
  localparam int SH = 13;

  // ---------------- clock / reset / DUT ----------------
  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 out_strobe = 1'b0;
  logic                 in_strobe;
  logic signed [IW-1:0] in_data = '0;
  logic                 out_valid;
  logic signed [OW-1:0] out_data;

  always #5 clock = ~clock;

  cic_interp10 #(
    .INTERPOLATION (R),
    .STAGES        (N),
    .IN_WIDTH      (IW),
    .OUT_WIDTH     (OW),
    .ACC_WIDTH     (AW),
    .OUT_SHIFT     (SH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .out_strobe (out_strobe),
    .in_strobe  (in_strobe),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic signed [63:0] act, input longint exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  int                   cyc = 0;
  int                   ns  = 0;
  logic                 exp_in_strobe = 1'b0;
  logic                 exp_valid = 1'b0;
  logic signed [OW-1:0] exp_hold = '0;
  logic                 inj = 1'b0;
  longint               samples[$];
  int                   x_idx[$];
  longint               x_val[$];
  logic signed [OW-1:0] exp_q[$];

  function automatic longint binom(input longint a, input int k);
    longint c;
    if (a < k) return 0;
    c = 1;
    for (int i = 0; i < k; i++) c = c * (a - i) / (i + 1);
    return c;
  endfunction

  // N-th backward difference of the accepted sample stream, delayed N-1 samples.
  function automatic longint comb_out();
    longint acc;
    int     k;
    int     j;
    acc = 0;
    k = samples.size();
    for (int i = 0; i <= N; i++) begin
      j = k - N + 1 - i;
      if (j >= 1 && j <= k) begin
        if (i % 2 == 1) acc -= binom(N, i) * samples[j-1];
        else            acc += binom(N, i) * samples[j-1];
      end
    end
    return acc;
  endfunction

  // Output at the n-th out_strobe: each injection at strobe m contributes
  // x * C(n-1-m, N-1), then round half up and clamp.
  function automatic logic signed [OW-1:0] expect_out(input int n);
    longint y;
    longint t;
    longint hi;
    longint lo;
    y = 0;
    foreach (x_idx[j]) if (x_idx[j] < n) y += x_val[j] * binom(n - 1 - x_idx[j], N - 1);
    t  = (y + (longint'(1) <<< (SH - 1))) >>> SH;
    hi = (longint'(1) <<< (OW - 1)) - 1;
    lo = -(longint'(1) <<< (OW - 1));
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    return OW'(t);
  endfunction

  always @(posedge clock) begin : model
    logic                 took;
    logic signed [OW-1:0] v;
    if (reset) begin
      cyc = 0;
      ns = 0;
      exp_in_strobe = 1'b0;
      exp_valid = 1'b0;
      exp_hold = '0;
      inj = 1'b0;
      samples.delete();
      x_idx.delete();
      x_val.delete();
      exp_q.delete();
    end else begin
      took = exp_in_strobe;
      cyc++;
      exp_valid = out_strobe;
      if (out_strobe) begin
        ns++;
        if (inj) begin
          x_idx.push_back(ns);
          x_val.push_back(comb_out());
          inj = 1'b0;
        end
        v = expect_out(ns);
        exp_q.push_back(v);
        exp_hold = v;
      end
      if (took) begin
        samples.push_back(longint'(in_data));
        inj = 1'b1;
      end
      exp_in_strobe = out_strobe && (ns % R == 0);
    end
  end

  // ---------------- scoreboard / compare ----------------
  int                   strobe_cyc[$];
  logic signed [OW-1:0] out_log[$];
  int                   out_log_cyc[$];

  always @(negedge clock) begin
    check("in_strobe", 64'(in_strobe), longint'(exp_in_strobe));
    check("out_valid", 64'(out_valid), longint'(exp_valid));
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_data: got %0d with no expected sample", out_data);
      end else begin
        check("out_data", 64'(out_data), longint'(exp_q.pop_front()));
      end
      out_log.push_back(out_data);
      out_log_cyc.push_back(cyc);
    end else begin
      check("out_hold", 64'(out_data), longint'(exp_hold));
    end
    if (in_strobe === 1'b1) strobe_cyc.push_back(cyc);
  end

  function automatic int sc(input int i);
    if (i < strobe_cyc.size()) return strobe_cyc[i];
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  int strobe_ph = 0;

  task automatic run(input int cycles, input int period);
    for (int i = 0; i < cycles; i++) begin
      out_strobe = (strobe_ph % period == 0);
      strobe_ph++;
      @(negedge clock);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    out_strobe = 1'b0;
    repeat (cycles) @(negedge clock);
    reset = 1'b0;
    strobe_ph = 0;
    #1;
    strobe_cyc.delete();
    out_log.delete();
    out_log_cyc.delete();
  endtask

  task automatic clear_logs();
    #1;
    strobe_cyc.delete();
    out_log.delete();
    out_log_cyc.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic signed [IW-1:0] tbl [8];
    bit     ok;
    int     nz;
    int     first_cyc;
    int     last_in;
    int     rises;
    longint sum;
    longint firsts [5];

    tbl[0] = 18'sd1000;   tbl[1] = -18'sd2000;  tbl[2] = 18'sd50000;  tbl[3] = -18'sd70000;
    tbl[4] = 18'sd131071; tbl[5] = -18'sd131072; tbl[6] = 18'sd12345; tbl[7] = 18'sd0;

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_in_strobe", 64'(in_strobe), 0);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_out_data", 64'(out_data), 0);

    // Cadence with continuous out_strobe, zero input
    do_reset(1);
    in_data = '0;
    run(35, 1);
    #1;
    check("cadence_first", sc(0), 10);
    check("cadence_second", sc(1), 20);
    check("cadence_third", sc(2), 30);
    check("zero_input_out", 64'(out_data), 0);

    // Impulse of 8192 on one accepted sample
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_strobe === 1'b1) begin
        ok = 1'b1;
        break;
      end
      run(1, 1);
    end
    check("impulse_wait", 64'(ok), 1);
    in_data = 18'sd8192;
    run(1, 1);
    in_data = '0;
    clear_logs();
    run(120, 1);
    #1;
    nz = 0;
    sum = 0;
    first_cyc = -1;
    last_in = -1;
    foreach (firsts[k]) firsts[k] = 0;
    foreach (out_log[j]) begin
      if (out_log[j] != 0) begin
        if (nz == 0) first_cyc = out_log_cyc[j];
        if (nz < 5) firsts[nz] = longint'(out_log[j]);
        nz++;
        sum += longint'(out_log[j]);
      end
    end
    foreach (strobe_cyc[j]) if (strobe_cyc[j] < first_cyc) last_in = strobe_cyc[j];
    check("impulse_taps", nz, 46);
    check("impulse_sum", sum, 100000);
    check("impulse_tap0", firsts[0], 1);
    check("impulse_tap1", firsts[1], 5);
    check("impulse_tap2", firsts[2], 15);
    check("impulse_tap3", firsts[3], 35);
    check("impulse_tap4", firsts[4], 70);
    check("impulse_latency", first_cyc - last_in, 7);

    // DC gain
    in_data = 18'sd8192;
    run(200, 1);
    check("dc_8192", 64'(out_data), 10000);

    // Saturation at both rails, monotone transition between them
    in_data = 18'sd131071;
    run(200, 1);
    check("sat_pos", 64'(out_data), 131071);
    in_data = -18'sd131072;
    clear_logs();
    run(200, 1);
    #1;
    rises = 0;
    foreach (out_log[j]) if (j > 0 && out_log[j] > out_log[j-1]) rises++;
    check("sat_transition_rises", rises, 0);
    check("sat_neg", 64'(out_data), -131072);

    // Mid-operation reset during a DC run
    in_data = 18'sd8192;
    run(150, 1);
    reset = 1'b1;
    out_strobe = 1'b1;
    @(negedge clock);
    check("midreset_in_strobe", 64'(in_strobe), 0);
    check("midreset_out_valid", 64'(out_valid), 0);
    check("midreset_out_data", 64'(out_data), 0);
    reset = 1'b0;
    strobe_ph = 0;
    clear_logs();
    run(25, 1);
    #1;
    check("midreset_first_strobe", sc(0), 10);
    check("midreset_second_strobe", sc(1), 20);

    // Sparse out_strobe (every 3rd cycle) with varying samples
    do_reset(2);
    for (int i = 0; i < 240; i++) begin
      in_data = tbl[i % 8];
      run(1, 3);
    end
    #1;
    check("sparse_first_strobe", sc(0), 28);
    check("sparse_period_a", sc(1) - sc(0), 30);
    check("sparse_period_b", sc(2) - sc(1), 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
